// File: rtl/pgr_apb_slave_pkg.sv
// Shared definitions for the APB test register bank: register offsets, FSM states,
// default ID value and the saturating counter helper.
package pgr_apb_slave_pkg;

    localparam logic [4:0] ADDR_ID      = 5'h00;
    localparam logic [4:0] ADDR_SCRATCH = 5'h04;
    localparam logic [4:0] ADDR_CTRL    = 5'h08;
    localparam logic [4:0] ADDR_STATUS  = 5'h0C;
    localparam logic [4:0] ADDR_WR_CNT  = 5'h10;
    localparam logic [4:0] ADDR_RD_CNT  = 5'h14;
    localparam logic [4:0] ADDR_ERR     = 5'h18;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5047_0001;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP,
        DONE
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pgr_apb_slave_regs_32bit_strb.sv
// DW-wide register with per-byte write strobes; resets to zero.
module pgr_apb_strb_reg
    import pgr_apb_slave_pkg::*;
#(
    parameter int DW = 32,
    parameter int SW = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [SW-1:0] strb,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (we) begin
            for (int unsigned k = 0; k < SW; k++) begin
                if (strb[k]) q_d[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pgr_apb_slave_regs_32bit.sv
// APB responder for the bridge test bank: programmable wait states, one-cycle p_rdy,
// byte-strobed SCRATCH/CTRL and saturating write/read/error counters.
module pgr_apb_slave_regs_32bit
    import pgr_apb_slave_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int          DW       = 32,
    parameter int          SW       = 4,
    parameter int          WAIT_CYC = 2,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_sel,
    input  logic          p_ce,
    input  logic          p_we,
    input  logic [SW-1:0] p_strb,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_rdy,
    output logic [DW-1:0] p_rdata,
    input  logic [31:0]   status_in,
    output logic [31:0]   ctrl_out
);

    state_e        state_q, state_d;
    logic [7:0]    wait_q, wait_d;
    logic          p_rdy_q, p_rdy_d;
    logic [DW-1:0] p_rdata_q, p_rdata_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
    logic [DW-1:0] scratch_q, ctrl_q, rd_mux;
    logic [4:0]    offs;
    logic          in_range, mapped, writable, start, commit;
    logic          scratch_we, ctrl_we;

    // Masking keeps p_addr[1:0] in the expression while ignoring its value.
    assign offs     = p_addr[4:0] & 5'h1C;
    assign in_range = (p_addr[AW-1:5] == '0);

    always_comb begin
        rd_mux   = '0;
        mapped   = 1'b0;
        writable = 1'b0;
        if (in_range) begin
            mapped = 1'b1;
            case (offs)
                ADDR_ID:      rd_mux = DW'(ID_VALUE);
                ADDR_SCRATCH: begin rd_mux = scratch_q; writable = 1'b1; end
                ADDR_CTRL:    begin rd_mux = ctrl_q;    writable = 1'b1; end
                ADDR_STATUS:  rd_mux = DW'(status_in);
                ADDR_WR_CNT:  rd_mux = DW'(wr_cnt_q);
                ADDR_RD_CNT:  rd_mux = DW'(rd_cnt_q);
                ADDR_ERR:     rd_mux = DW'(err_cnt_q);
                default:      mapped = 1'b0;
            endcase
        end
    end

    // The wait counter counts ACCESS cycles, so commit fires on the edge that
    // makes p_rdy visible exactly WAIT_CYC+1 cycles after p_ce was sampled high.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        p_rdy_d   = 1'b0;
        p_rdata_d = p_rdata_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        start     = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (p_sel) begin
                    if (p_ce) start = 1'b1;
                    else      state_d = SETUP;
                end
            end
            SETUP: begin
                if (!p_sel)    state_d = IDLE;
                else if (p_ce) start = 1'b1;
            end
            ACCESS: begin
                if (!p_ce)                           state_d = IDLE;
                else if (int'(wait_q) + 1 == WAIT_CYC) commit = 1'b1;
                else                                 wait_d = wait_q + 8'd1;
            end
            RESP:    state_d = DONE;
            DONE:    if (!p_ce) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start) begin
            wait_d = '0;
            if (WAIT_CYC == 0) commit = 1'b1;
            else               state_d = ACCESS;
        end
        if (commit) begin
            state_d = RESP;
            p_rdy_d = 1'b1;
            if (p_we) begin
                p_rdata_d = '0;
                wr_cnt_d  = sat_inc(wr_cnt_q);
                if (!writable) err_cnt_d = sat_inc(err_cnt_q);
            end else begin
                p_rdata_d = rd_mux;
                rd_cnt_d  = sat_inc(rd_cnt_q);
                if (!mapped) err_cnt_d = sat_inc(err_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            p_rdy_q   <= 1'b0;
            p_rdata_q <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            p_rdy_q   <= p_rdy_d;
            p_rdata_q <= p_rdata_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign scratch_we = commit && p_we && in_range && (offs == ADDR_SCRATCH);
    assign ctrl_we    = commit && p_we && in_range && (offs == ADDR_CTRL);

    pgr_apb_strb_reg #(.DW(DW), .SW(SW)) u_scratch (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (scratch_we),
        .strb  (p_strb),
        .wdata (p_wdata),
        .q     (scratch_q)
    );

    pgr_apb_strb_reg #(.DW(DW), .SW(SW)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ctrl_we),
        .strb  (p_strb),
        .wdata (p_wdata),
        .q     (ctrl_q)
    );

    assign p_rdy    = p_rdy_q;
    assign p_rdata  = p_rdata_q;
    assign ctrl_out = ctrl_q[31:0];

endmodule

// File: tb/tb_pgr_apb_slave_regs_32bit.sv
// Randomised and directed APB accesses checked against a behavioural register-bank model.
module tb_pgr_apb_slave_regs_32bit;

    localparam int W = 5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        p_sel = 1'b0, p_ce = 1'b0, p_we = 1'b0;
    logic [3:0]  p_strb = '0;
    logic [15:0] p_addr = '0;
    logic [31:0] p_wdata = '0, status_in = '0;
    logic        p_rdy;
    logic [31:0] p_rdata, ctrl_out;

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] m_scratch = '0, m_ctrl = '0;
    int          m_wr = 0, m_rd = 0, m_err = 0;

    always #5 clk = ~clk;

    pgr_apb_slave_regs_32bit #(
        .AW(16), .DW(32), .SW(4), .WAIT_CYC(W), .ID_VALUE(32'h5047_0001)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_sel     (p_sel),
        .p_ce      (p_ce),
        .p_we      (p_we),
        .p_strb    (p_strb),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_rdy     (p_rdy),
        .p_rdata   (p_rdata),
        .status_in (status_in),
        .ctrl_out  (ctrl_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, want);
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        if (a[15:5] != 11'd0) return 32'h0;
        case (a[4:2])
            3'd0:    return 32'h5047_0001;
            3'd1:    return m_scratch;
            3'd2:    return m_ctrl;
            3'd3:    return status_in;
            3'd4:    return m_wr;
            3'd5:    return m_rd;
            3'd6:    return m_err;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (st[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    task automatic m_reset();
        m_scratch = '0; m_ctrl = '0; m_wr = 0; m_rd = 0; m_err = 0;
    endtask

    task automatic apb(input logic we, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd);
        logic [31:0] want;
        int          lat;
        bit          got;
        @(negedge clk);
        p_sel = 1'b1; p_ce = 1'b0; p_we = we; p_addr = a; p_wdata = wd; p_strb = st;
        status_in = $urandom;
        @(negedge clk);
        p_ce = 1'b1;
        want = m_read(a);
        lat = 0; got = 1'b0;
        while (!got && lat < W + 20) begin
            @(negedge clk);
            lat++;
            got = p_rdy;
        end
        chk($sformatf("latency@%h", a), lat, W + 1);
        rd = p_rdata;
        if (!we) chk($sformatf("rdata@%h", a), p_rdata, want);
        if (we) begin
            m_wr = sat(m_wr);
            if (a[15:5] == 11'd0 && a[4:2] == 3'd1)      m_scratch = merge(m_scratch, wd, st);
            else if (a[15:5] == 11'd0 && a[4:2] == 3'd2) m_ctrl = merge(m_ctrl, wd, st);
            else                                          m_err = sat(m_err);
        end else begin
            m_rd = sat(m_rd);
            if (a[15:5] != 11'd0 || a[4:2] == 3'd7) m_err = sat(m_err);
        end
        @(negedge clk);
        chk("rdy_single", p_rdy, 0);
        p_ce = 1'b0; p_sel = 1'b0;
        @(negedge clk);
        if (!we) chk("rdata_hold", p_rdata, want);
        chk("ctrl_out", ctrl_out, m_ctrl);
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] a;
        bit          seen;

        repeat (3) @(negedge clk);
        chk("rst_rdy", p_rdy, 0);
        chk("rst_rdata", p_rdata, 0);
        chk("rst_ctrl", ctrl_out, 0);
        rst_n = 1'b1;

        apb(1'b0, 16'h0000, '0, 4'h0, rd);
        chk("id_value", rd, 32'h5047_0001);
        apb(1'b0, 16'h0014, '0, 4'h0, rd);
        chk("rd_cnt_1", rd, 32'd1);

        apb(1'b1, 16'h0004, 32'hA5A5_A5A5, 4'hF, rd);
        apb(1'b1, 16'h0004, 32'h1234_5678, 4'b0101, rd);
        apb(1'b0, 16'h0006, '0, 4'h0, rd);
        chk("scratch_strb", rd, 32'hA534_A578);
        apb(1'b0, 16'h0010, '0, 4'h0, rd);
        chk("wr_cnt_2", rd, 32'd2);

        apb(1'b1, 16'h0000, 32'hDEAD_BEEF, 4'hF, rd);
        apb(1'b0, 16'h001C, '0, 4'h0, rd);
        chk("unmapped_rd", rd, 32'h0);
        apb(1'b0, 16'h0018, '0, 4'h0, rd);
        chk("err_cnt_2", rd, 32'd2);

        // Abort after two ACCESS cycles
        @(negedge clk);
        p_sel = 1'b1; p_we = 1'b1; p_addr = 16'h0008; p_wdata = 32'hCAFE_F00D; p_strb = 4'hF;
        @(negedge clk);
        p_ce = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= p_rdy; end
        p_ce = 1'b0; p_sel = 1'b0;
        repeat (W + 4) begin @(negedge clk); seen |= p_rdy; end
        chk("abort_no_rdy", seen, 0);
        chk("abort_ctrl", ctrl_out, m_ctrl);
        apb(1'b0, 16'h0010, '0, 4'h0, rd);
        apb(1'b0, 16'h0014, '0, 4'h0, rd);
        apb(1'b0, 16'h0018, '0, 4'h0, rd);
        apb(1'b0, 16'h0008, '0, 4'h0, rd);

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = a | (16'd1 << $urandom_range(5, 15));
            apb(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
        end

        // Reset in the middle of a CTRL write
        @(negedge clk);
        p_sel = 1'b1; p_we = 1'b1; p_addr = 16'h0008; p_wdata = 32'hFFFF_FFFF; p_strb = 4'hF;
        @(negedge clk);
        p_ce = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_mid_ctrl", ctrl_out, 0);
        chk("rst_mid_rdy", p_rdy, 0);
        repeat (2) @(negedge clk);
        p_ce = 1'b0; p_sel = 1'b0;
        rst_n = 1'b1;
        apb(1'b0, 16'h0008, '0, 4'h0, rd);
        chk("ctrl_after_rst", rd, 32'h0);
        apb(1'b0, 16'h0010, '0, 4'h0, rd);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
